// File: rtl/duel_pkg.sv
// rtl/duel_pkg.sv - shared encodings and helpers for the duel sequencer and its display decoders
package duel_pkg;

    localparam int HP_W   = 2;
    localparam int TIME_W = 14;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_OPEN   = 4'd2,
        ST_ANSWER = 4'd3,
        ST_OVER   = 4'd4
    } state_t;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P1     = 2'b01;
    localparam logic [1:0] P2     = 2'b10;

    // HP never wraps below zero
    function automatic logic [HP_W-1:0] hp_dec(input logic [HP_W-1:0] hp);
        return (hp == '0) ? '0 : hp - 1'b1;
    endfunction

endpackage

// File: rtl/duel_if.sv
// rtl/duel_if.sv - button/datapath side signal bundle of the duel sequencer
interface duel_if;
    import duel_pkg::*;

    logic              START;
    logic              Q_READY;
    logic              Q_REQ;
    logic [1:0]        BUZZ;
    logic              JUDG_VALID;
    logic              JUDG_OK;
    logic [1:0]        GRANT;
    logic [1:0]        LOCK;
    logic [HP_W-1:0]   HP1;
    logic [HP_W-1:0]   HP2;
    logic [1:0]        WINNER;
    logic [3:0]        STATE;
    logic [TIME_W-1:0] TIME_LEFT;

    // sequencer side
    modport master (
        input  START, Q_READY, BUZZ, JUDG_VALID, JUDG_OK,
        output Q_REQ, GRANT, LOCK, HP1, HP2, WINNER, STATE, TIME_LEFT
    );

    // buttons / datapath side
    modport slave (
        output START, Q_READY, BUZZ, JUDG_VALID, JUDG_OK,
        input  Q_REQ, GRANT, LOCK, HP1, HP2, WINNER, STATE, TIME_LEFT
    );

endinterface

// File: rtl/duel_timer.sv
// rtl/duel_timer.sv - answer timer (prescaler + loadable down-counter), used under DUEL_TIMEOUT_EN
module duel_timer
    import duel_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int ANSWER_TICKS = 10000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              run,
    input  logic              clear,
    output logic [TIME_W-1:0] count,
    output logic              expire
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] TICKS_INIT = TIME_W'(ANSWER_TICKS);

    logic [PRE_W-1:0] presc_q;
    logic             tick;

    assign tick   = run && (presc_q == PRE_LAST);
    assign expire = tick && (count == TIME_W'(1));

    // prescaler restarts on every load so the first tick is a full TICK_DIV away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (load || clear) begin
            presc_q <= '0;
        end else if (run) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    // ticks remaining; forced to zero whenever the answer window is not active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= TICKS_INIT;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/duel_sequencer.sv
// rtl/duel_sequencer.sv - two-player round sequencer/arbiter; answer timer enabled by DUEL_TIMEOUT_EN
module duel_sequencer #(
    parameter int HP_INIT      = 3,
    parameter int TICK_DIV     = 50000,
    parameter int ANSWER_TICKS = 10000
) (
    input  logic   CLK,
    input  logic   RST,
    duel_if.master bus
);
    import duel_pkg::*;

    localparam logic [HP_W-1:0] HP_START = HP_W'(HP_INIT);

    state_t            state_q, state_n;
    logic [1:0]        grant_q, grant_n;
    logic [1:0]        lock_q, lock_n;
    logic [1:0]        winner_q, winner_n;
    logic [HP_W-1:0]   hp1_q, hp1_n;
    logic [HP_W-1:0]   hp2_q, hp2_n;
    logic              ptr_q, ptr_n;      // 0: P1 wins a tie, 1: P2 wins a tie
    logic              q_req_q, q_req_n;

    logic [1:0]        buzz_avail;
    logic [1:0]        buzz_pick;
    logic              in_answer;
    logic              judge_hit;
    logic              judge_miss;
    logic              timeout;
    logic [HP_W-1:0]   opp_hp;
    logic              opp_last;
    logic [TIME_W-1:0] time_left;

    assign in_answer  = (state_q == ST_ANSWER);
    assign buzz_avail = (state_q == ST_OPEN) ? (bus.BUZZ & ~lock_q) : P_NONE;
    assign buzz_pick  = (buzz_avail == 2'b11) ? (ptr_q ? P2 : P1) : buzz_avail;
    assign judge_hit  = in_answer && bus.JUDG_VALID && bus.JUDG_OK;
    // a judge result in the same cycle as the timeout wins over it
    assign judge_miss = in_answer && (bus.JUDG_VALID ? !bus.JUDG_OK : timeout);
    assign opp_hp     = (grant_q == P1) ? hp2_q : hp1_q;
    assign opp_last   = (opp_hp <= HP_W'(1));

`ifdef DUEL_TIMEOUT_EN
    logic timer_load;
    logic timer_clear;

    assign timer_load  = (state_n == ST_ANSWER) && (state_q != ST_ANSWER);
    assign timer_clear = (state_n != ST_ANSWER);

    duel_timer #(
        .TICK_DIV     (TICK_DIV),
        .ANSWER_TICKS (ANSWER_TICKS)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (RST),
        .load   (timer_load),
        .run    (in_answer),
        .clear  (timer_clear),
        .count  (time_left),
        .expire (timeout)
    );
`else
    assign timeout   = 1'b0;
    assign time_left = '0;
`endif

    // state and all registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            grant_q  <= P_NONE;
            lock_q   <= 2'b00;
            winner_q <= P_NONE;
            hp1_q    <= HP_START;
            hp2_q    <= HP_START;
            ptr_q    <= 1'b0;
            q_req_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            grant_q  <= grant_n;
            lock_q   <= lock_n;
            winner_q <= winner_n;
            hp1_q    <= hp1_n;
            hp2_q    <= hp2_n;
            ptr_q    <= ptr_n;
            q_req_q  <= q_req_n;
        end
    end

    // round flow
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:   if (bus.START) state_n = ST_FETCH;
            ST_FETCH:  if (bus.Q_READY) state_n = ST_OPEN;
            ST_OPEN:   if (buzz_pick != P_NONE) state_n = ST_ANSWER;
            ST_ANSWER: begin
                if (judge_hit) begin
                    state_n = opp_last ? ST_OVER : ST_FETCH;
                end else if (judge_miss) begin
                    state_n = ((lock_q | grant_q) == 2'b11) ? ST_FETCH : ST_OPEN;
                end
            end
            ST_OVER:   if (bus.START) state_n = ST_FETCH;
            default:   state_n = ST_IDLE;
        endcase
    end

    // next values of grant, lockout, HP, winner, priority pointer and fetch pulse
    always_comb begin
        grant_n  = grant_q;
        lock_n   = lock_q;
        winner_n = winner_q;
        hp1_n    = hp1_q;
        hp2_n    = hp2_q;
        ptr_n    = ptr_q;
        q_req_n  = (state_n == ST_FETCH) && (state_q != ST_FETCH);

        if (buzz_pick != P_NONE) begin
            grant_n = buzz_pick;
            ptr_n   = (buzz_pick == P1);
        end

        if (judge_hit) begin
            grant_n = P_NONE;
            if (grant_q == P1) begin
                hp2_n = hp_dec(hp2_q);
            end else begin
                hp1_n = hp_dec(hp1_q);
            end
            if (opp_last) begin
                winner_n = grant_q;
            end
        end

        if (judge_miss) begin
            grant_n = P_NONE;
            lock_n  = lock_q | grant_q;
        end

        // every new question starts with nobody locked out
        if (state_n == ST_FETCH) begin
            lock_n = 2'b00;
        end

        if ((state_q == ST_OVER) && bus.START) begin
            hp1_n    = HP_START;
            hp2_n    = HP_START;
            winner_n = P_NONE;
        end
    end

    assign bus.STATE     = state_q;
    assign bus.GRANT     = grant_q;
    assign bus.LOCK      = lock_q;
    assign bus.WINNER    = winner_q;
    assign bus.HP1       = hp1_q;
    assign bus.HP2       = hp2_q;
    assign bus.Q_REQ     = q_req_q;
    assign bus.TIME_LEFT = time_left;

endmodule

// File: tb/tb_duel_sequencer.sv
// tb/tb_duel_sequencer.sv - directed scoreboard bench for duel_sequencer
module tb_duel_sequencer;

    localparam int S_STATE = 0, S_GRANT = 1, S_LOCK = 2, S_HP1 = 3;
    localparam int S_HP2 = 4, S_WIN = 5, S_QREQ = 6, S_TL = 7;

`ifdef DUEL_TIMEOUT_EN
    localparam int TL_ENTRY = 3;
`else
    localparam int TL_ENTRY = 0;
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   m_hp1;
    int   m_hp2;

    duel_if bus ();

    duel_sequencer #(
        .HP_INIT      (3),
        .TICK_DIV     (4),
        .ANSWER_TICKS (3)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_STATE: return {12'd0, bus.STATE};
            S_GRANT: return {14'd0, bus.GRANT};
            S_LOCK:  return {14'd0, bus.LOCK};
            S_HP1:   return {14'd0, bus.HP1};
            S_HP2:   return {14'd0, bus.HP2};
            S_WIN:   return {14'd0, bus.WINNER};
            S_QREQ:  return {15'd0, bus.Q_REQ};
            default: return {2'd0, bus.TIME_LEFT};
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = 16'(val);
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_cmp++;
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.START = 1'b1;
        cyc();
        bus.START = 1'b0;
    endtask

    task automatic buzz(input logic [1:0] b);
        bus.BUZZ = b;
        cyc();
        bus.BUZZ = 2'b00;
    endtask

    task automatic judge(input logic ok);
        bus.JUDG_VALID = 1'b1;
        bus.JUDG_OK    = ok;
        cyc();
        bus.JUDG_VALID = 1'b0;
        bus.JUDG_OK    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_hp1 = 3;
        m_hp2 = 3;
        rst_n = 1'b0;
        bus.START = 1'b0;
        bus.Q_READY = 1'b0;
        bus.BUZZ = 2'b00;
        bus.JUDG_VALID = 1'b0;
        bus.JUDG_OK = 1'b0;
        repeat (2) cyc();

        want("rst_state", S_STATE, 0); want("rst_grant", S_GRANT, 0);
        want("rst_lock", S_LOCK, 0);   want("rst_hp1", S_HP1, 3);
        want("rst_hp2", S_HP2, 3);     want("rst_win", S_WIN, 0);
        want("rst_qreq", S_QREQ, 0);   want("rst_tl", S_TL, 0);
        drain();

        rst_n = 1'b1;
        cyc();
        start_pulse();
        want("fetch_state", S_STATE, 1); want("fetch_qreq", S_QREQ, 1);
        drain();
        cyc();
        want("fetch_hold", S_STATE, 1); want("qreq_once", S_QREQ, 0);
        drain();
        bus.Q_READY = 1'b1;
        cyc();
        want("open_state", S_STATE, 2); want("open_hp1", S_HP1, 3);
        want("open_hp2", S_HP2, 3);
        drain();

        buzz(2'b11);
        want("tie_grant", S_GRANT, 1); want("tie_state", S_STATE, 3);
        want("entry_tl", S_TL, TL_ENTRY);
        drain();
        judge(1'b0);
        want("wrong1_lock", S_LOCK, 1); want("wrong1_state", S_STATE, 2);
        want("wrong1_grant", S_GRANT, 0); want("wrong1_hp2", S_HP2, 3);
        drain();
        buzz(2'b01);
        want("locked_state", S_STATE, 2); want("locked_grant", S_GRANT, 0);
        drain();
        buzz(2'b10);
        want("p2_grant", S_GRANT, 2); want("p2_state", S_STATE, 3);
        drain();
        judge(1'b0);
        want("both_state", S_STATE, 1); want("both_lock", S_LOCK, 0);
        want("both_qreq", S_QREQ, 1); want("both_hp1", S_HP1, 3);
        want("both_hp2", S_HP2, 3); want("both_grant", S_GRANT, 0);
        drain();
        cyc();
        want("refetch_open", S_STATE, 2); want("refetch_qreq", S_QREQ, 0);
        drain();
        judge(1'b1);
        want("judge_open_state", S_STATE, 2); want("judge_open_hp2", S_HP2, 3);
        drain();

        for (int k = 0; k < 3; k++) begin
            buzz(2'b01);
            want("win_grant", S_GRANT, 1); want("win_state", S_STATE, 3);
            drain();
            judge(1'b1);
            m_hp2--;
            want("win_hp2", S_HP2, m_hp2); want("win_grant_clr", S_GRANT, 0);
            if (m_hp2 != 0) begin
                want("win_fetch", S_STATE, 1); want("win_qreq", S_QREQ, 1);
                drain();
                cyc();
                want("win_open", S_STATE, 2);
            end else begin
                want("over_state", S_STATE, 4); want("over_winner", S_WIN, 1);
            end
            drain();
        end

        buzz(2'b10);
        want("over_buzz_state", S_STATE, 4); want("over_buzz_grant", S_GRANT, 0);
        want("over_hold_win", S_WIN, 1);
        drain();
        start_pulse();
        m_hp2 = 3;
        want("restart_state", S_STATE, 1); want("restart_hp1", S_HP1, 3);
        want("restart_hp2", S_HP2, 3); want("restart_win", S_WIN, 0);
        want("restart_qreq", S_QREQ, 1);
        drain();
        cyc();
        want("restart_open", S_STATE, 2);
        drain();

        buzz(2'b11);
        want("ptr_p2_grant", S_GRANT, 2);
        drain();
        judge(1'b1);
        m_hp1--;
        want("p2_hit_hp1", S_HP1, m_hp1); want("p2_hit_state", S_STATE, 1);
        drain();
        cyc();

`ifdef DUEL_TIMEOUT_EN
        buzz(2'b01);
        want("tmo_entry_tl", S_TL, 3);
        drain();
        for (int i = 1; i <= 11; i++) begin
            cyc();
            if (i == 4) want("tmo_tl_2", S_TL, 2);
            if (i == 8) want("tmo_tl_1", S_TL, 1);
            if (i == 11) want("tmo_pre_state", S_STATE, 3);
            drain();
        end
        cyc();
        want("tmo_state", S_STATE, 2); want("tmo_lock", S_LOCK, 1);
        want("tmo_grant", S_GRANT, 0); want("tmo_tl", S_TL, 0);
        want("tmo_hp2", S_HP2, m_hp2);
        drain();
        buzz(2'b10);
        want("tmo2_grant", S_GRANT, 2);
        drain();
        repeat (11) cyc();
        want("tmo2_tl", S_TL, 1);
        drain();
        judge(1'b1);
        m_hp1--;
        want("expiry_judge_hp1", S_HP1, m_hp1); want("expiry_judge_state", S_STATE, 1);
        want("expiry_judge_lock", S_LOCK, 0); want("expiry_judge_tl", S_TL, 0);
        drain();
        cyc();
`else
        buzz(2'b01);
        repeat (20) cyc();
        want("notmo_state", S_STATE, 3); want("notmo_tl", S_TL, 0);
        want("notmo_grant", S_GRANT, 1);
        drain();
        judge(1'b1);
        m_hp2--;
        want("notmo_hp2", S_HP2, m_hp2); want("notmo_fetch", S_STATE, 1);
        drain();
        cyc();
`endif

        while (m_hp2 > 1) begin
            buzz(2'b01);
            judge(1'b1);
            m_hp2--;
            want("drain_hp2", S_HP2, m_hp2);
            drain();
            cyc();
        end
        buzz(2'b01);
        want("pre_rst_state", S_STATE, 3); want("pre_rst_hp2", S_HP2, 1);
        drain();

        bus.JUDG_VALID = 1'b1;
        bus.JUDG_OK    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        want("arst_state", S_STATE, 0); want("arst_grant", S_GRANT, 0);
        want("arst_lock", S_LOCK, 0);   want("arst_hp1", S_HP1, 3);
        want("arst_hp2", S_HP2, 3);     want("arst_win", S_WIN, 0);
        want("arst_qreq", S_QREQ, 0);   want("arst_tl", S_TL, 0);
        drain();
        bus.JUDG_VALID = 1'b0;
        bus.JUDG_OK    = 1'b0;
        #2 rst_n = 1'b1;
        cyc();
        want("post_rst_state", S_STATE, 0); want("post_rst_hp2", S_HP2, 3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
